serial_subtractor: RTL and testbench

//   Bit-serial, LSB-first subtractor that computes diff = a - b over WIDTH bits.
//   It uses one full-subtractor cell (difference plus borrow) and a borrow flip-flop.
//   It is the inverse arithmetic companion of the combinational full_adder cell.
//   It trades WIDTH cycles of latency for single-cell area.
//   It sits between operand producers and result consumers, using valid/ready on both sides.

---
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell plus a borrow flop,
// computing diff = a - b over WIDTH cycles with valid/ready on both sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; the producer holds valid until then, ready never depends on valid.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             x, y, d, br_next;
  logic [WIDTH-1:0] res_shift;

  assign x         = sa_q[0];
  assign y         = sb_q[0];
  assign d         = x ^ y ^ borrow_q;
  assign br_next   = (~x & y) | (~(x ^ y) & borrow_q);
  // New difference bit enters at the MSB so the LSB-first stream lands in place.
  assign res_shift = WIDTH'({d, res_q} >> 1);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        res_d    = res_shift;
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        borrow_d = br_next;
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_shift;
          bout_d  = br_next;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q == S_RUN);
  assign out_valid   = (state_q == S_HOLD);
  assign diff        = diff_q;
  assign bout        = bout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: a WIDTH=8 instance and a WIDTH=1 instance,
// with expected results queued at accept time and popped when out_valid rises.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, bout, busy;
  logic [7:0] a, b, diff;
  logic [1:0] dbg_state;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, bout1, busy1;
  logic [0:0] a1, b1, diff1;
  logic [1:0] dbg_state1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .busy(busy), .dbg_state_o(dbg_state)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1), .busy(busy1), .dbg_state_o(dbg_state1)
  );

  logic [8:0] exp_q[$];
  logic [1:0] exp1_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept8(input logic [7:0] av, input logic [7:0] bv);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept8_ready", in_ready, 1);
    in_valid = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic send8(input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] dv;
    dv = av - bv;
    exp_q.push_back({(av < bv) ? 1'b1 : 1'b0, dv});
    accept8(av, bv);
  endtask

  task automatic collect8();
    int n = 0;
    logic [8:0] e;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("latency8", n, 8);
    check("queue8_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
    check("diff8", diff, e[7:0]);
    check("bout8", bout, e[8]);
    check("hold8_in_ready", in_ready, 0);
  endtask

  task automatic release8();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release8_out_valid", out_valid, 0);
    check("release8_in_ready", in_ready, 1);
  endtask

  task automatic send1(input logic av, input logic bv);
    exp1_q.push_back({~av & bv, av ^ bv});
    in_valid1 = 1'b1; a1 = av; b1 = bv;
    @(posedge clk); #1;
    in_valid1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
  endtask

  task automatic collect1();
    int n = 0;
    logic [1:0] e;
    while (!out_valid1 && n < 10) begin @(posedge clk); #1; n++; end
    check("latency1", n, 1);
    e = (exp1_q.size() > 0) ? exp1_q.pop_front() : 2'bxx;
    check("diff1", diff1, e[0]);
    check("bout1", bout1, e[1]);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("release1_in_ready", in_ready1, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_state", dbg_state, 0);
    check("rst1_in_ready", in_ready1, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic cases and corners
    send8(8'd5, 8'd3);     check("run_busy", busy, 1); collect8(); release8();
    send8(8'd3, 8'd5);     collect8(); release8();
    send8(8'd0, 8'd0);     collect8(); release8();
    send8(8'd255, 8'd255); collect8(); release8();
    send8(8'd0, 8'd1);     collect8(); release8();
    send8(8'd255, 8'd0);   collect8(); release8();
    for (int i = 0; i < 4; i++) begin
      send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      collect8(); release8();
    end

    // Back-pressure: result held, new pair during HOLD ignored
    send8(8'd7, 8'd9);
    collect8();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_diff", diff, 8'hfe);
      check("bp_bout", bout, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b1; a = 8'd200; b = 8'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold_ignore_valid", out_valid, 1);
    check("hold_ignore_diff", diff, 8'hfe);
    check("hold_ignore_busy", busy, 0);
    release8();
    send8(8'd200, 8'd100); collect8(); release8();

    // Asynchronous reset mid-RUN aborts the operation
    accept8(8'd9, 8'd4);
    repeat (4) begin @(posedge clk); #1; end
    check("abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy_low", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send8(8'd9, 8'd4); collect8(); release8();

    // WIDTH=1 instance, exhaustive
    for (int i = 0; i < 4; i++) begin
      send1(i[1], i[0]);
      collect1();
    end

    check("queue8_empty", exp_q.size(), 0);
    check("queue1_empty", exp1_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
